// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS encodings (opcodes, functs, ALUOp) and the
//                ID/EX control bundle type.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;

    // ALUOp handed to the EX-stage ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Control bits carried through ID/EX
    typedef struct packed {
        logic regdst;
        logic alusrc;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
        logic branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/main_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : main_decoder
//  Description : Combinational ID-stage main control decoder. Maps opcode and
//                funct onto the control bundle, ALUOp, rt-as-source flag and
//                an illegal-instruction flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_decoder
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output logic [1:0] aluop,
    output logic       rt_used,
    output logic       illegal
);

    // Decode opcode/funct; unknown encodings yield no control and illegal=1
    always_comb begin
        ctrl    = CTRL_NONE;
        aluop   = ALUOP_ADD;
        rt_used = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                // rt is read by every R-type, legal or not
                rt_used = 1'b1;
                case (funct)
                    F_ADD, F_ADDU, F_SUB, F_AND, F_OR, F_NOR, F_SLT: begin
                        aluop         = ALUOP_FUNCT;
                        ctrl.regdst   = 1'b1;
                        ctrl.regwrite = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            OP_SW: begin
                rt_used       = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            OP_BEQ: begin
                rt_used     = 1'b1;
                aluop       = ALUOP_SUB;
                ctrl.branch = 1'b1;
            end
            OP_ADDI: begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule : main_decoder
`default_nettype wire

// File: rtl/id_ex_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_ctrl
//  Description : ID-stage decode, ID/EX control pipeline register, load-use
//                hazard detection and flush/stall/bubble arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_ctrl
    import mips_pkg::*;
#(
    parameter bit NOP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        stall_in,
    input  logic        flush,
    output logic        hazard_stall,
    output logic        ex_valid,
    output logic [1:0]  ex_aluop,
    output logic [5:0]  ex_funct,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic        ex_regdst,
    output logic        ex_alusrc,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic        ex_regwrite,
    output logic        ex_branch,
    output logic        illegal_instr
);

    logic [4:0] rs, rt, rd;
    logic [5:0] funct;
    logic       unused_shamt;

    ctrl_t      dec_ctrl;
    logic [1:0] dec_aluop;
    logic       dec_rt_used;
    logic       dec_illegal;

    // ID/EX state and its next value
    ctrl_t      ctrl_q,  ctrl_d;
    logic       valid_q, valid_d;
    logic [1:0] aluop_q, aluop_d;
    logic [5:0] funct_q, funct_d;
    logic [4:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic       illegal_q, set_illegal;

    assign rs           = id_instr[25:21];
    assign rt           = id_instr[20:16];
    assign rd           = id_instr[15:11];
    assign funct        = id_instr[5:0];
    assign unused_shamt = ^id_instr[10:6];

    main_decoder u_main_decoder (
        .opcode  (id_instr[31:26]),
        .funct   (funct),
        .ctrl    (dec_ctrl),
        .aluop   (dec_aluop),
        .rt_used (dec_rt_used),
        .illegal (dec_illegal)
    );

    // Load-use: the load in EX writes a register the ID instruction reads
    always_comb begin
        hazard_stall = id_valid & valid_q & ctrl_q.memread & (rt_q != 5'd0) &
                       ((rt_q == rs) | (dec_rt_used & (rt_q == rt)));
    end

    // Next ID/EX contents: flush > external stall > hazard bubble > load
    always_comb begin
        ctrl_d      = ctrl_q;
        valid_d     = valid_q;
        aluop_d     = aluop_q;
        funct_d     = funct_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        set_illegal = 1'b0;
        if (flush || (!stall_in && (hazard_stall || !id_valid))) begin
            // Bubble: nothing valid, fields parked at zero
            ctrl_d  = CTRL_NONE;
            valid_d = 1'b0;
            aluop_d = ALUOP_ADD;
            funct_d = 6'd0;
            rs_d    = 5'd0;
            rt_d    = 5'd0;
            rd_d    = 5'd0;
        end else if (!stall_in) begin
            funct_d = funct;
            rs_d    = rs;
            rt_d    = rt;
            rd_d    = rd;
            if (dec_illegal) begin
                set_illegal = 1'b1;
                ctrl_d      = CTRL_NONE;
                aluop_d     = ALUOP_ADD;
                valid_d     = !NOP_ON_ILLEGAL;
                if (NOP_ON_ILLEGAL) begin
                    funct_d = 6'd0;
                    rs_d    = 5'd0;
                    rt_d    = 5'd0;
                    rd_d    = 5'd0;
                end
            end else begin
                ctrl_d  = dec_ctrl;
                aluop_d = dec_aluop;
                valid_d = 1'b1;
            end
        end
    end

    // ID/EX pipeline register with sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= CTRL_NONE;
            valid_q   <= 1'b0;
            aluop_q   <= 2'b00;
            funct_q   <= 6'd0;
            rs_q      <= 5'd0;
            rt_q      <= 5'd0;
            rd_q      <= 5'd0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            aluop_q   <= aluop_d;
            funct_q   <= funct_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_q | set_illegal;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_aluop      = aluop_q;
    assign ex_funct      = funct_q;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_rd         = rd_q;
    assign ex_regdst     = ctrl_q.regdst;
    assign ex_alusrc     = ctrl_q.alusrc;
    assign ex_memread    = ctrl_q.memread;
    assign ex_memwrite   = ctrl_q.memwrite;
    assign ex_memtoreg   = ctrl_q.memtoreg;
    assign ex_regwrite   = ctrl_q.regwrite;
    assign ex_branch     = ctrl_q.branch;
    assign illegal_instr = illegal_q;

endmodule : id_ex_ctrl
`default_nettype wire

// File: tb/tb_id_ex_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_ctrl
//  Description : Directed, table-driven self-checking bench for id_ex_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_ctrl;

    localparam logic [31:0] I_ADD   = 32'h012A4020; // add  $8,$9,$10
    localparam logic [31:0] I_SUB   = 32'h018D5822; // sub  $11,$12,$13
    localparam logic [31:0] I_LW9   = 32'h8C490000; // lw   $9,0($2)
    localparam logic [31:0] I_LW5   = 32'h8C450000; // lw   $5,0($2)
    localparam logic [31:0] I_ADDI9 = 32'h20890005; // addi $9,$4,5
    localparam logic [31:0] I_SW    = 32'hACC50004; // sw   $5,4($6)
    localparam logic [31:0] I_BEQ   = 32'h10220003; // beq  $1,$2,3
    localparam logic [31:0] I_ILLR  = 32'h012A4003; // R-type funct 000011
    localparam logic [31:0] I_ILLOP = 32'hFC000000; // opcode 111111

    // control order: regdst alusrc memread memwrite memtoreg regwrite branch
    localparam logic [6:0] C_R    = 7'b1000010;
    localparam logic [6:0] C_LW   = 7'b0110110;
    localparam logic [6:0] C_SW   = 7'b0101000;
    localparam logic [6:0] C_BEQ  = 7'b0000001;
    localparam logic [6:0] C_ADDI = 7'b0100010;
    localparam logic [6:0] C_NONE = 7'b0000000;

    typedef struct {
        logic        fl, st, vld;
        logic [31:0] instr;
        logic        haz;
        logic        valid;
        logic [1:0]  aluop;
        logic [6:0]  ctrl;
        logic [5:0]  funct;
        logic [4:0]  rs, rt, rd;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_instr;
    logic        id_valid, stall_in, flush;

    logic        hazard_stall, ex_valid, illegal_instr;
    logic [1:0]  ex_aluop;
    logic [5:0]  ex_funct;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_branch;

    logic        hz0, v0, ill0;
    logic [1:0]  a0;
    logic [5:0]  f0;
    logic [4:0]  s0, t0, d0;
    logic        c0_rd, c0_as, c0_mr, c0_mw, c0_mt, c0_rw, c0_br;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    id_ex_ctrl #(.NOP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .stall_in(stall_in), .flush(flush), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_funct(ex_funct),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_branch(ex_branch),
        .illegal_instr(illegal_instr)
    );

    // Same stimulus, illegal instructions enter as valid no-ops
    id_ex_ctrl #(.NOP_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .stall_in(stall_in), .flush(flush), .hazard_stall(hz0),
        .ex_valid(v0), .ex_aluop(a0), .ex_funct(f0),
        .ex_rs(s0), .ex_rt(t0), .ex_rd(d0),
        .ex_regdst(c0_rd), .ex_alusrc(c0_as), .ex_memread(c0_mr),
        .ex_memwrite(c0_mw), .ex_memtoreg(c0_mt),
        .ex_regwrite(c0_rw), .ex_branch(c0_br),
        .illegal_instr(ill0)
    );

    function automatic logic [31:0] pack_out();
        return {ex_valid, ex_aluop,
                ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_branch,
                ex_funct, ex_rs, ex_rt, ex_rd, illegal_instr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    vec_t vecs[24];

    function automatic vec_t mk(input logic fl, input logic st, input logic vld, input logic [31:0] instr,
                                input logic haz, input logic valid, input logic [1:0] aluop,
                                input logic [6:0] ctrl, input logic [5:0] funct,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic ill);
        vec_t v;
        v.fl = fl; v.st = st; v.vld = vld; v.instr = instr; v.haz = haz; v.valid = valid;
        v.aluop = aluop; v.ctrl = ctrl; v.funct = funct; v.rs = rs; v.rt = rt; v.rd = rd; v.ill = ill;
        return v;
    endfunction

    initial begin
        //                fl st vl instr    haz val alu    ctrl    funct  rs  rt  rd  ill
        vecs[0]  = mk(0, 0, 1, I_ADD,   0, 1, 2'b10, C_R,    6'h20, 9,  10, 8,  0);
        vecs[1]  = mk(0, 0, 1, I_LW9,   0, 1, 2'b00, C_LW,   6'h00, 2,  9,  0,  0);
        vecs[2]  = mk(0, 0, 1, I_ADD,   1, 0, 2'b00, C_NONE, 6'h00, 0,  0,  0,  0);
        vecs[3]  = mk(0, 0, 1, I_ADD,   0, 1, 2'b10, C_R,    6'h20, 9,  10, 8,  0);
        vecs[4]  = mk(0, 0, 1, I_LW9,   0, 1, 2'b00, C_LW,   6'h00, 2,  9,  0,  0);
        vecs[5]  = mk(0, 0, 1, I_ADDI9, 0, 1, 2'b00, C_ADDI, 6'h05, 4,  9,  0,  0);
        vecs[6]  = mk(0, 0, 1, I_LW5,   0, 1, 2'b00, C_LW,   6'h00, 2,  5,  0,  0);
        vecs[7]  = mk(0, 0, 1, I_SW,    1, 0, 2'b00, C_NONE, 6'h00, 0,  0,  0,  0);
        vecs[8]  = mk(0, 0, 1, I_SW,    0, 1, 2'b00, C_SW,   6'h04, 6,  5,  0,  0);
        vecs[9]  = mk(0, 0, 1, I_SUB,   0, 1, 2'b10, C_R,    6'h22, 12, 13, 11, 0);
        vecs[10] = mk(1, 1, 1, I_BEQ,   0, 0, 2'b00, C_NONE, 6'h00, 0,  0,  0,  0);
        vecs[11] = mk(0, 0, 1, I_BEQ,   0, 1, 2'b01, C_BEQ,  6'h03, 1,  2,  0,  0);
        vecs[12] = mk(0, 1, 1, I_ADD,   0, 1, 2'b01, C_BEQ,  6'h03, 1,  2,  0,  0);
        vecs[13] = mk(1, 0, 1, I_ILLOP, 0, 0, 2'b00, C_NONE, 6'h00, 0,  0,  0,  0);
        vecs[14] = mk(0, 1, 1, I_ILLR,  0, 0, 2'b00, C_NONE, 6'h00, 0,  0,  0,  0);
        vecs[15] = mk(0, 0, 0, I_ADD,   0, 0, 2'b00, C_NONE, 6'h00, 0,  0,  0,  0);
        vecs[16] = mk(0, 0, 1, I_LW9,   0, 1, 2'b00, C_LW,   6'h00, 2,  9,  0,  0);
        vecs[17] = mk(0, 1, 1, I_ADD,   1, 1, 2'b00, C_LW,   6'h00, 2,  9,  0,  0);
        vecs[18] = mk(1, 0, 1, I_ADD,   1, 0, 2'b00, C_NONE, 6'h00, 0,  0,  0,  0);
        vecs[19] = mk(0, 0, 1, I_LW9,   0, 1, 2'b00, C_LW,   6'h00, 2,  9,  0,  0);
        vecs[20] = mk(0, 0, 0, I_ADD,   0, 0, 2'b00, C_NONE, 6'h00, 0,  0,  0,  0);
        vecs[21] = mk(0, 0, 1, I_ILLR,  0, 0, 2'b00, C_NONE, 6'h00, 0,  0,  0,  1);
        vecs[22] = mk(0, 0, 1, I_ADD,   0, 1, 2'b10, C_R,    6'h20, 9,  10, 8,  1);
        vecs[23] = mk(0, 0, 1, I_ILLOP, 0, 0, 2'b00, C_NONE, 6'h00, 0,  0,  0,  1);

        rst_n = 1'b0; id_instr = 32'd0; id_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        #12;
        check("reset_outputs", pack_out(), 32'd0);
        check("reset_hazard", {31'd0, hazard_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            flush = vecs[i].fl; stall_in = vecs[i].st; id_valid = vecs[i].vld; id_instr = vecs[i].instr;
            #2;
            check($sformatf("v%0d_hazard", i), {31'd0, hazard_stall}, {31'd0, vecs[i].haz});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_idex", i), pack_out(),
                  {vecs[i].valid, vecs[i].aluop, vecs[i].ctrl, vecs[i].funct,
                   vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].ill});
            if (i == 21)
                check("nop0_illegal_entry",
                      {22'd0, v0, a0, c0_rd, c0_as, c0_mr, c0_mw, c0_mt, c0_rw, c0_br, ill0},
                      {22'd0, 1'b1, 2'b00, 7'b0000000, 1'b1});
        end

        // Asynchronous reset while a load-use stall is being signalled
        @(negedge clk);
        flush = 1'b0; stall_in = 1'b0; id_valid = 1'b1; id_instr = I_LW9;
        @(posedge clk);
        #1;
        @(negedge clk);
        id_instr = I_ADD;
        #2;
        check("pre_reset_hazard", {31'd0, hazard_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_hazard", {31'd0, hazard_stall}, 32'd0);
        check("async_reset_outputs", pack_out(), 32'd0);
        check("async_reset_nop0_sticky", {31'd0, ill0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        id_instr = I_BEQ;
        @(posedge clk);
        #1;
        check("post_reset_beq", pack_out(),
              {1'b1, 2'b01, C_BEQ, 6'h03, 5'd1, 5'd2, 5'd0, 1'b0});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_id_ex_ctrl
`default_nettype wire

// File: doc/id_ex_ctrl.md
Name: id_ex_ctrl

Overview:
ID-stage main control decoder plus ID/EX control pipeline register for the MIPS pipeline. It is the producing end of the ALUOp/funct interface consumed by the EX-stage ALU control decoder. It decodes the IF/ID instruction, registers the control bundle into ID/EX, and detects load-use hazards. It also arbitrates flush, bubble and external-stall events.

Parameters:
NOP_ON_ILLEGAL, 1, 1: an illegal opcode/funct enters ID/EX as a bubble; 0: it enters with RegWrite/MemWrite forced 0 but ex_valid=1.

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
id_instr  in  32  instruction from IF/ID
id_valid  in  1  IF/ID holds a real instruction
stall_in  in  1  external hold (memory wait): ID/EX holds its contents
flush  in  1  branch/jump taken: kill the ID instruction
hazard_stall  out  1  combinational; holds PC and IF/ID this cycle
ex_valid  out  1  ID/EX holds a real instruction
ex_aluop  out  2  00 add, 01 sub, 10 use funct
ex_funct  out  6  id_instr[5:0], registered
ex_rs, ex_rt, ex_rd  out  5 each  registered register fields
ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_branch  out  1 each  registered control
illegal_instr  out  1  sticky; set when an illegal instruction is decoded with id_valid=1, cleared only by reset

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output is 0, including illegal_instr. hazard_stall is combinational and is 0 while ex_memread=0.
- Decode. opcode=id_instr[31:26], funct=id_instr[5:0]:
  - 000000 R-type, legal funct only (100000, 100001, 100010, 100100, 100101, 100111, 101010): aluop=10, regdst=1, regwrite=1.
  - 100011 lw: aluop=00, alusrc=1, memread=1, memtoreg=1, regwrite=1.
  - 101011 sw: aluop=00, alusrc=1, memwrite=1.
  - 000100 beq: aluop=01, branch=1.
  - 001000 addi: aluop=00, alusrc=1, regwrite=1.
  - Anything else, including an R-type with other funct, is illegal.
- Source usage: rs is always a source. rt is a source only for R-type, sw and beq.
- Load-use: hazard_stall = id_valid & ex_valid & ex_memread & (ex_rt!=0) & ((ex_rt==rs) | (rt_used & ex_rt==rt)).
- Per-rising-edge priority:
  1. flush=1: ID/EX loads a bubble (all control and ex_valid 0; fields don't-care, driven 0).
  2. stall_in=1: ID/EX holds every field.
  3. hazard_stall=1: ID/EX loads a bubble.
  4. Otherwise ID/EX loads the decode of id_instr, with ex_valid=id_valid. When id_valid=0, all control bits load 0.
- A bubble has ex_valid=0, so a load-use stall lasts exactly one cycle: the next cycle's comparison sees ex_memread=0.
- flush together with a hazard: flush wins and hazard_stall still asserts combinationally. The upstream PC logic gives flush priority.
- Latency: decode to ID/EX is one cycle. No combinational path from id_instr to the ex_* outputs.
- illegal_instr sets on the same edge that would load the illegal instruction. This applies only to priority level 4; under flush or stall there is no set.
- Illegal handling: with NOP_ON_ILLEGAL=1 it enters as a bubble. With NOP_ON_ILLEGAL=0 it enters with ex_valid=1, aluop=00 and all other control bits 0.
- Reset mid-stall: all state clears and hazard_stall drops immediately.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI.
  - Funct constants: F_ADD, F_ADDU, F_SUB, F_AND, F_OR, F_NOR, F_SLT.
  - ALUOp constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
  - A ctrl_t struct holding the seven control bits.
- One combinational sub-module, main_decoder (opcode, funct -> ctrl_t, aluop, rt_used, illegal). The register and hazard logic stay in id_ex_ctrl.

Test Plan:
- Reset then id_valid=1, instr=0x012A4020 (add $8,$9,$10) -> next edge: ex_valid=1, aluop=10, funct=100000, regdst=1, regwrite=1, rd=8.
- lw $9,0($2) (0x8C490000) followed by add $8,$9,$10 -> hazard_stall=1 during the cycle add sits in ID. One bubble enters (ex_valid=0). The next edge loads add with aluop=10.
- lw $9,0($2) then addi $3,$4,5 (rt=3, not a source, rs=4) -> hazard_stall stays 0 and no bubble is inserted.
- beq present while flush=1 and stall_in=1 -> ID/EX loads a bubble (flush wins). On the following edge with stall_in=1 only, ID/EX holds.
- R-type funct=000011 (illegal), NOP_ON_ILLEGAL=1 -> ex_valid=0, illegal_instr=1, and illegal_instr stays 1 through later legal instructions until rst_n pulses low.
- rst_n asserted low mid-cycle while hazard_stall=1 -> all outputs are 0 immediately, without waiting for a clk edge.
